// File: rtl/par_mem_pkg.sv
// par_mem_pkg -- shared definitions for the parity-protected memory.
//
// Contents:
//   DEF_DATA_W / DEF_ADDR_W / DEF_ECNT_W : default parameter values
//   state_t                              : controller state (CLEAR, IDLE)
//   addr_bits()                          : index width needed for a given depth
//
// Build option: defining PAR_MEM_ERR_INJ_EN adds the err_inj port to par_mem.

package par_mem_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_ECNT_W = 8;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    // Width of an index into a DEPTH-word array; at least one bit so that
    // a single-word memory still has a legal index vector.
    function automatic int addr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/par_mem_array.sv
// par_mem_array -- plain synchronous RAM, one write port, one registered
// read port. No reset: contents are initialised by the owner.
//
// Ports:
//   clk    in   clock, rising edge
//   we     in   write enable
//   waddr  in   write word index
//   wdata  in   write word
//   re     in   read enable; rdata updates only when re is high
//   raddr  in   read word index
//   rdata  out  registered read word (holds between reads)

module par_mem_array
    import par_mem_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_W + 1,
    parameter int DEPTH = 2 ** DEF_ADDR_W,
    parameter int AW    = addr_bits(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/par_mem.sv
// par_mem -- word memory that stores an even-parity bit beside every word,
// checks it on read and counts parity failures.
//
// After reset the controller sweeps every word to zero (CLEAR, DEPTH cycles,
// busy=1, requests ignored) and then serves requests (IDLE).
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   synchronous, active-high reset
//   write       in   write request (wins over a simultaneous read)
//   read        in   read request
//   data_in     in   write data
//   address     in   word address; address >= DEPTH is rejected
//   err_inj     in   (only with PAR_MEM_ERR_INJ_EN) store inverted parity
//   data_out    out  {parity, data} of the last accepted read
//   valid       out  pulse: data_out updated by an accepted read
//   busy        out  high while clearing after reset
//   parity_err  out  pulse with valid: stored parity does not match data
//   addr_err    out  pulse the cycle after an out-of-range request
//   err_cnt     out  saturating count of parity_err pulses
//
// Build option: PAR_MEM_ERR_INJ_EN adds the err_inj input.

module par_mem
    import par_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = 2 ** ADDR_W,
    parameter int ECNT_W = DEF_ECNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write,
    input  logic              read,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] address,
`ifdef PAR_MEM_ERR_INJ_EN
    input  logic              err_inj,
`endif
    output logic [DATA_W:0]   data_out,
    output logic              valid,
    output logic              busy,
    output logic              parity_err,
    output logic              addr_err,
    output logic [ECNT_W-1:0] err_cnt
);

    localparam int AW = addr_bits(DEPTH);
    // One extra bit so DEPTH == 2**ADDR_W is representable in the compare.
    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [AW-1:0]   LAST_PTR = AW'(DEPTH - 1);

    state_t          state;
    logic [AW-1:0]   clr_ptr;

    logic            in_range;
    logic            idle;
    logic            clearing;
    logic            wr_acc;
    logic            rd_acc;
    logic            rd_oob;
    logic            req_oob;
    logic            inj;
    logic            par_bit;

    logic            ram_we;
    logic [AW-1:0]   ram_waddr;
    logic [DATA_W:0] ram_wdata;
    logic [DATA_W:0] ram_q;

    // data_out is forced to zero after reset or an out-of-range read until
    // the next accepted read loads the RAM output register.
    logic            zero_q;

`ifdef PAR_MEM_ERR_INJ_EN
    assign inj = err_inj;
`else
    assign inj = 1'b0;
`endif

    assign in_range = {1'b0, address} < DEPTH_L;
    assign idle     = (state == IDLE);
    assign clearing = (state == CLEAR) && !reset;

    // Write has priority: a simultaneous read is dropped entirely.
    assign wr_acc  = idle && write && in_range;
    assign rd_acc  = idle && read && !write && in_range;
    assign rd_oob  = idle && read && !write && !in_range;
    assign req_oob = idle && (write || read) && !in_range;

    assign par_bit = (^data_in) ^ inj;

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = address[AW-1:0];
        ram_wdata = {par_bit, data_in};
        if (clearing) begin
            ram_we    = 1'b1;
            ram_waddr = clr_ptr;
            ram_wdata = '0;
        end else if (wr_acc) begin
            ram_we    = 1'b1;
        end
    end

    par_mem_array #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (rd_acc),
        .raddr (address[AW-1:0]),
        .rdata (ram_q)
    );

    // Controller: CLEAR sweeps words 0..DEPTH-1, one per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_ptr == LAST_PTR) begin
                        state   <= IDLE;
                        clr_ptr <= '0;
                    end else begin
                        clr_ptr <= clr_ptr + 1'b1;
                    end
                end
                IDLE: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= CLEAR;
                    clr_ptr <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid    <= 1'b0;
            addr_err <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            valid    <= rd_acc;
            addr_err <= req_oob;
            if (rd_acc) begin
                zero_q <= 1'b0;
            end else if (rd_oob) begin
                zero_q <= 1'b1;
            end
        end
    end

    assign data_out   = zero_q ? '0 : ram_q;
    assign parity_err = valid && (ram_q[DATA_W] != (^ram_q[DATA_W-1:0]));
    assign busy       = (state == CLEAR);

    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt <= '0;
        end else if (parity_err && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_par_mem.sv
// tb_par_mem -- directed self-checking bench for par_mem (DEPTH=100).
// Inputs change on the falling edge; outputs are sampled on the falling
// edge following each active edge.

module tb_par_mem;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 100;
    localparam int ECNT_W = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              write = 1'b0;
    logic              read = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic [ADDR_W-1:0] address = '0;
    logic              err_inj = 1'b0;
    logic [DATA_W:0]   data_out;
    logic              valid;
    logic              busy;
    logic              parity_err;
    logic              addr_err;
    logic [ECNT_W-1:0] err_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    par_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .ECNT_W (ECNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .write      (write),
        .read       (read),
        .data_in    (data_in),
        .address    (address),
`ifdef PAR_MEM_ERR_INJ_EN
        .err_inj    (err_inj),
`endif
        .data_out   (data_out),
        .valid      (valid),
        .busy       (busy),
        .parity_err (parity_err),
        .addr_err   (addr_err),
        .err_cnt    (err_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs (called at a falling edge), return at the
    // falling edge after the active edge so registered outputs are visible.
    task automatic step(input logic w, input logic r, input logic [15:0] a,
                        input logic [7:0] d, input logic inj);
        write   = w;
        read    = r;
        address = a;
        data_in = d;
        err_inj = inj;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        end
    endtask

    // Pulse reset for one edge, then count cycles with busy high while
    // throwing requests at the memory that must all be ignored.
    task automatic reset_and_count(output int cycles);
        int bad;
        reset = 1'b1;
        step(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        reset  = 1'b0;
        cycles = 0;
        bad    = 0;
        for (int i = 0; i < 1000; i++) begin
            if (valid || addr_err) bad++;
            if (!busy) break;
            cycles++;
            write   = i[0];
            read    = 1'b1;
            address = i[1] ? 16'd200 : 16'd5;
            data_in = 8'h55;
            @(posedge clk);
            @(negedge clk);
        end
        write = 1'b0;
        read  = 1'b0;
        check("clear_ignores_requests", bad, 0);
    endtask

    initial begin
        int cyc;
        int miss;

        @(negedge clk);

        // Reset values
        reset = 1'b1;
        step(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        check("rst_data_out", data_out, 9'h000);
        check("rst_valid", valid, 1'b0);
        check("rst_parity_err", parity_err, 1'b0);
        check("rst_addr_err", addr_err, 1'b0);
        check("rst_err_cnt", err_cnt, 8'h00);
        check("rst_busy", busy, 1'b1);

        // Clear sweep length
        reset_and_count(cyc);
        check("clear_cycles", cyc, DEPTH);

        // Cleared contents, including first and last word and the word
        // targeted during CLEAR
        step(1'b0, 1'b1, 16'd0, 8'h00, 1'b0);
        check("clr_rd0_valid", valid, 1'b1);
        check("clr_rd0_data", data_out, 9'h000);
        check("clr_rd0_perr", parity_err, 1'b0);
        step(1'b0, 1'b1, 16'd99, 8'h00, 1'b0);
        check("clr_rd99_data", data_out, 9'h000);
        step(1'b0, 1'b1, 16'd5, 8'h00, 1'b0);
        check("clr_rd5_data", data_out, 9'h000);
        check("clr_rd5_valid", valid, 1'b1);

        // Write A5 then read it back
        step(1'b1, 1'b0, 16'h0010, 8'hA5, 1'b0);
        check("wr_no_valid", valid, 1'b0);
        step(1'b0, 1'b1, 16'h0010, 8'h00, 1'b0);
        check("a5_valid", valid, 1'b1);
        check("a5_data", data_out, 9'h0A5);

        // Two writes, back-to-back reads in reverse order
        step(1'b1, 1'b0, 16'h0020, 8'h07, 1'b0);
        step(1'b1, 1'b0, 16'h0021, 8'h3C, 1'b0);
        step(1'b0, 1'b1, 16'h0021, 8'h00, 1'b0);
        check("b2b_first_valid", valid, 1'b1);
        check("b2b_first_data", data_out, 9'h03C);
        step(1'b0, 1'b1, 16'h0020, 8'h00, 1'b0);
        check("b2b_second_valid", valid, 1'b1);
        check("b2b_second_data", data_out, 9'h107);
        check("b2b_second_perr", parity_err, 1'b0);

        // Hold when idle
        step(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        check("hold_valid", valid, 1'b0);
        check("hold_data", data_out, 9'h107);

        // Simultaneous write and read: read dropped
        step(1'b1, 1'b1, 16'h0030, 8'hFF, 1'b0);
        check("wr_rd_valid", valid, 1'b0);
        check("wr_rd_hold", data_out, 9'h107);
        step(1'b0, 1'b1, 16'h0030, 8'h00, 1'b0);
        check("wr_rd_later_data", data_out, 9'h0FF);

        // Read right after write
        step(1'b1, 1'b0, 16'h0040, 8'h5A, 1'b0);
        step(1'b0, 1'b1, 16'h0040, 8'h00, 1'b0);
        check("raw_data", data_out, 9'h05A);

        // Last word with odd parity
        step(1'b1, 1'b0, 16'd99, 8'h80, 1'b0);
        step(1'b0, 1'b1, 16'd99, 8'h00, 1'b0);
        check("last_word_data", data_out, 9'h180);

        // Out-of-range read
        step(1'b0, 1'b1, 16'd200, 8'h00, 1'b0);
        check("oob_rd_addr_err", addr_err, 1'b1);
        check("oob_rd_valid", valid, 1'b0);
        check("oob_rd_data", data_out, 9'h000);
        step(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        check("oob_addr_err_pulse", addr_err, 1'b0);

        // Out-of-range boundary write that would alias word 99
        step(1'b1, 1'b0, 16'd227, 8'hEE, 1'b0);
        check("oob_wr_addr_err", addr_err, 1'b1);
        step(1'b1, 1'b0, 16'd100, 8'hEE, 1'b0);
        check("oob_wr100_addr_err", addr_err, 1'b1);
        step(1'b0, 1'b1, 16'd99, 8'h00, 1'b0);
        check("oob_wr_no_alias", data_out, 9'h180);
        check("inrange_no_addr_err", addr_err, 1'b0);
        check("no_parity_errs", err_cnt, 8'h00);

`ifdef PAR_MEM_ERR_INJ_EN
        // Injected parity error, counter saturation
        step(1'b1, 1'b0, 16'h0050, 8'h01, 1'b1);
        miss = 0;
        for (int i = 1; i <= 300; i++) begin
            step(1'b0, 1'b1, 16'h0050, 8'h00, 1'b0);
            if (!(valid && parity_err)) miss++;
            if (i == 10) check("inj_cnt_10", err_cnt, 8'd9);
        end
        check("inj_perr_every_read", miss, 0);
        check("inj_data", data_out, 9'h001);
        step(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        check("inj_cnt_saturated", err_cnt, 8'hFF);
        check("inj_perr_pulse", parity_err, 1'b0);
`endif

        // Reset mid-operation restarts the clear
        reset_and_count(cyc);
        check("op_reset_cycles", cyc, DEPTH);
        check("op_reset_err_cnt", err_cnt, 8'h00);
        step(1'b0, 1'b1, 16'h0010, 8'h00, 1'b0);
        check("op_reset_cleared", data_out, 9'h000);
        check("op_reset_rd_valid", valid, 1'b1);

        // Reset mid-CLEAR restarts from word 0
        reset = 1'b1;
        step(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
        reset = 1'b0;
        idle_cycles(30);
        check("mid_clear_busy", busy, 1'b1);
        reset_and_count(cyc);
        check("mid_clear_reset_cycles", cyc, DEPTH);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/par_mem.md
PAR_MEM -- requirements
Module: par_mem

Interface
REQ-001 Parameter DATA_W, default 8: data word width in bits.
REQ-002 Parameter ADDR_W, default 16: address width in bits.
REQ-003 Parameter DEPTH, default 2**ADDR_W: number of implemented words, 1 <= DEPTH <= 2**ADDR_W.
REQ-004 Parameter ECNT_W, default 8: parity error counter width.
REQ-005 clk  input  1  sole clock, rising edge; one clock, all logic synchronous to clk.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 write  input  1  write request.
REQ-008 read  input  1  read request.
REQ-009 data_in  input  DATA_W  write data.
REQ-010 address  input  ADDR_W  word address.
REQ-011 data_out  output  DATA_W+1  registered read result {parity, data}.
REQ-012 valid  output  1  one-cycle pulse: data_out updated by an accepted read.
REQ-013 busy  output  1  high during post-reset clear; requests ignored.
REQ-014 parity_err  output  1  one-cycle pulse, coincident with valid: stored parity mismatch.
REQ-015 addr_err  output  1  one-cycle pulse: request with address >= DEPTH.
REQ-016 err_cnt  output  ECNT_W  saturating count of parity_err pulses.

Function
REQ-017 FSM states CLEAR, IDLE; CLEAR writes data 0, parity 0 to word clr_ptr, clr_ptr increments 0..DEPTH-1, then transitions to IDLE; CLEAR lasts exactly DEPTH cycles.
REQ-018 busy SHALL be 1 exactly while in CLEAR.
REQ-019 In IDLE, write=1 with address < DEPTH stores {^data_in, data_in} at address on that edge.
REQ-020 In IDLE, read=1, write=0, address < DEPTH: next cycle data_out = stored {parity, data}, valid=1 (latency 1).
REQ-021 parity_err=1 with valid when stored parity != ^stored data.
REQ-022 Simultaneous write and read: write performed, read dropped, valid stays 0.
REQ-023 Back-to-back reads every cycle SHALL each produce valid one cycle later.
REQ-024 Read of address just written in previous cycle returns new data.
REQ-025 Address >= DEPTH: write dropped, read dropped with data_out = 0 and valid = 0; addr_err pulses the following cycle.
REQ-026 data_out holds its last value when no read is accepted.
REQ-027 err_cnt increments per parity_err, saturates at 2**ECNT_W-1, never wraps.
REQ-028 Requests during CLEAR are ignored, with no valid, addr_err or memory update.

Reset
REQ-029 reset=1 on a clk edge: FSM enters CLEAR, clr_ptr=0, data_out=0, valid=0, parity_err=0, addr_err=0, err_cnt=0, busy=1 from the next cycle.
REQ-030 Reset asserted mid-CLEAR or mid-operation restarts CLEAR from word 0.

Configuration
REQ-031 Macro PAR_MEM_ERR_INJ_EN defined: adds input err_inj (1 bit); a write with err_inj=1 stores the inverted parity bit.
REQ-032 Macro absent: port err_inj does not exist; parity is always stored correctly.

Structure
REQ-033 Package par_mem_pkg holds the FSM state enum (CLEAR, IDLE) and the default parameter constants.
REQ-034 Sub-module par_mem_array: plain synchronous RAM of DEPTH x (DATA_W+1) bits with one write port and one registered read port; par_mem holds the FSM, parity and error logic.

Verification
REQ-035 Reset, then count cycles -> busy high exactly DEPTH cycles; read of any address then returns 0x000 with parity_err=0.
REQ-036 Write 8'hA5 at address 16'h0010, then read 16'h0010 -> data_out=9'h0A5, valid one cycle after read.
REQ-037 Write 8'h07 at 16'h0020 and 8'h3C at 16'h0021, then read both in reverse order -> 9'h107, 9'h03C.
REQ-038 Assert write and read together at 16'h0030 with 8'hFF -> no valid; a later read returns 9'h0FF.
REQ-039 With PAR_MEM_ERR_INJ_EN, write 8'h01 with err_inj=1, read 300 times -> parity_err each read, err_cnt stops at 255.
REQ-040 With DEPTH=100, read address 200 -> addr_err pulses, valid=0; reset mid-CLEAR -> busy lasts a further full DEPTH cycles.
